// File: rtl/digit_scan_ctrl.sv
// Four-digit seven-segment scan controller: one-hot digit select, per-frame value snapshot,
// active-low anodes with slot-start blanking. Optional macro: LEADING_ZERO_BLANK_EN.
module digit_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] value,
    output logic [3:0]  sel,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q, tick_d;
    logic             upper_zero;

    always_comb begin
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    shadow_d = value;
                    tick_d   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        sel_d   = 4'b0001 << slot_d;
        digit_d = shadow_d[{slot_d, 2'b00} +: 4];
    end

    // Digits at or above the current slot all zero means this one is a leading zero.
    always_comb begin
        case (slot_d)
            2'd1:    upper_zero = (shadow_d[15:4] == 12'h000);
            2'd2:    upper_zero = (shadow_d[15:8] == 8'h00);
            2'd3:    upper_zero = (shadow_d[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    always_comb begin
        an_d = 4'b1111;
        if (en && !(int'(cnt_d) < BLANK_CYCLES)) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (!upper_zero) an_d = ~sel_d;
`else
            an_d = ~sel_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            slot_q   <= 2'd0;
            shadow_q <= 16'h0000;
            sel_q    <= 4'b0001;
            digit_q  <= 4'h0;
            an_q     <= 4'b1111;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

`ifndef LEADING_ZERO_BLANK_EN
    logic unused_lzb;
    assign unused_lzb = upper_zero;
`endif

    assign sel        = sel_q;
    assign digit      = digit_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: two instances (4/1 and 2/0) checked against a frame-position model.
module tb_digit_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [15:0] value;
    logic [3:0]  sel1, digit1, an1, sel2, digit2, an2;
    logic        ft1, ft2;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value),
        .sel(sel1), .digit(digit1), .an(an1), .frame_tick(ft1));

    digit_scan_ctrl #(.PRESCALE(2), .BLANK_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value),
        .sel(sel2), .digit(digit2), .an(an2), .frame_tick(ft2));

    int checks = 0, failures = 0;

    // Model: position within the frame in enabled cycles, last snapshot, display-lit flag, tick.
    int          p1, p2;
    logic [15:0] snap1, snap2;
    bit          lit1, lit2, tk1, tk2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int pre, input bit r, input bit e, input logic [15:0] v,
                       inout int p, inout logic [15:0] snap, inout bit lit, inout bit tk);
        if (!r) begin
            p = 0; snap = 16'h0; lit = 0; tk = 0;
        end else if (!e) begin
            lit = 0; tk = 0;
        end else begin
            p   = (p + 1) % (4 * pre);
            lit = 1;
            tk  = (p == 0);
            if (tk) snap = v;
        end
    endtask

    task automatic verify(input string tag, input int pre, input int blank, input int p,
                          input logic [15:0] snap, input bit lit, input bit tk,
                          input logic [3:0] s, input logic [3:0] d, input logic [3:0] a,
                          input logic f);
        int slot;
        logic [3:0] es, ea;
        logic [15:0] hi;
        slot = p / pre;
        es   = 4'(1 << slot);
        hi   = snap >> (4 * slot);
        ea   = 4'hF;
        if (lit && (p % pre) >= blank) begin
            ea = ~es;
`ifdef LEADING_ZERO_BLANK_EN
            if (slot != 0 && hi == 16'h0) ea = 4'hF;
`endif
        end
        chk({tag, "_sel"}, 16'(s), 16'(es));
        chk({tag, "_digit"}, 16'(d), 16'(hi[3:0]));
        chk({tag, "_an"}, 16'(a), 16'(ea));
        chk({tag, "_tick"}, 16'(f), 16'(tk));
    endtask

    task automatic step(input bit r, input bit e, input logic [15:0] v);
        rst_n = r; en = e; value = v;
        @(posedge clk);
        adv(4, r, e, v, p1, snap1, lit1, tk1);
        adv(2, r, e, v, p2, snap2, lit2, tk2);
        #1;
        verify("p4b1", 4, 1, p1, snap1, lit1, tk1, sel1, digit1, an1, ft1);
        verify("p2b0", 2, 0, p2, snap2, lit2, tk2, sel2, digit2, an2, ft2);
    endtask

    initial begin
        bit   reached;
        bit   r, e;
        logic [15:0] v;
        p1 = 0; p2 = 0; snap1 = 0; snap2 = 0; lit1 = 0; lit2 = 0; tk1 = 0; tk2 = 0;
        rst_n = 1'b0; en = 1'b0; value = 16'h0;

        // 1: reset then a first frame of zeros, tick 16 cycles after release
        repeat (3) step(0, 0, 16'h1234);
        chk("reset_sel", 16'(sel1), 16'h1);
        chk("reset_an", 16'(an1), 16'hF);
        repeat (16) step(1, 1, 16'h1234);
        chk("first_tick", 16'(ft1), 16'h1);
        chk("first_tick_digit", 16'(digit1), 16'h4);
        chk("first_tick_sel", 16'(sel1), 16'h1);

        // 2: mid-frame value change is deferred to the next wrap
        repeat (6) step(1, 1, 16'h1234);
        repeat (30) step(1, 1, 16'hABCD);

        // 3: pause in slot 2, then resume
        reached = 0;
        for (int i = 0; i < 32 && !reached; i++) begin
            if (p1 == 9) reached = 1;
            else step(1, 1, 16'hABCD);
        end
        chk("reach_slot2", 16'(reached), 16'h1);
        repeat (10) step(1, 0, 16'h5555);
        chk("paused_sel", 16'(sel1), 16'h4);
        chk("paused_an", 16'(an1), 16'hF);
        repeat (8) step(1, 1, 16'hABCD);

        // 4: reset mid-slot 3
        reached = 0;
        for (int i = 0; i < 32 && !reached; i++) begin
            if (p1 == 14) reached = 1;
            else step(1, 1, 16'h9876);
        end
        chk("reach_slot3", 16'(reached), 16'h1);
        step(0, 1, 16'h9876);
        chk("midreset_digit", 16'(digit1), 16'h0);
        repeat (16) step(1, 1, 16'h9876);
        chk("post_reset_tick", 16'(ft1), 16'h1);

        // 5: leading-zero patterns
        repeat (20) step(1, 1, 16'h0050);
        repeat (20) step(1, 1, 16'h0000);
        repeat (20) step(1, 1, 16'h0007);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) != 0);
            e = ($urandom_range(0, 6) != 0);
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            step(r, e, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing scan controller for a 4-digit, common-anode seven-segment display. It steps a one-hot digit select across four slots at a programmable rate and snapshots the 16-bit display value once per frame so all four digits come from the same value. It outputs the selected nibble for the decoder, the active-low anode drives and a frame strobe. It sits between the value source and the 7-segment decoder, and replaces free-running select logic.

## Interface

Parameters:
- PRESCALE, 100000, clocks per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 1000, dead-time clocks at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < PRESCALE; 0 disables blanking.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  scan enable; low freezes the scan and turns the display off.
- value  in  16  display value; digit k = value[4k+3:4k].
- sel  out  4  one-hot digit select; sel[k] = slot k.
- digit  out  4  nibble of the snapshot selected by sel.
- an  out  4  anode drives, active-low; 1 = digit off.
- frame_tick  out  1  one-cycle pulse marking the start of a frame.

## Operation

- State:
  - cnt: prescaler, 0..PRESCALE-1.
  - slot: 2-bit, 0..3.
  - shadow: 16-bit snapshot register.
- Every output is registered and is computed from next-state values, so sel, digit, an and frame_tick change on the same edge.
- Reset (rst_n=0 at an edge): cnt=0, slot=0, shadow=0, sel=4'b0001, digit=0, an=4'b1111, frame_tick=0. Reset mid-slot or mid-frame aborts immediately; no partial state is kept.
- en=1:
  - If cnt == PRESCALE-1: cnt←0 and slot←slot+1 mod 4.
  - Otherwise: cnt←cnt+1.
- Slot sequence: 0→1→2→3→0. sel = 0001, 0010, 0100, 1000.
- Snapshot: on the edge where slot wraps 3→0, shadow←value, and frame_tick=1 for that one cycle. At all other times frame_tick=0 and shadow holds.
- digit = shadow[4·slot+3 : 4·slot], using the next-state slot and shadow.
- an: 4'b1111 if cnt_next < BLANK_CYCLES; otherwise ~sel_next.
- en=0:
  - cnt, slot and shadow hold. sel and digit hold.
  - an=4'b1111 from the next edge. frame_tick=0.
  - When en returns, counting resumes from the held cnt. No reset of the slot occurs.
- value changes mid-frame have no effect until the next 3→0 wrap. After reset the first frame displays 0000.

## Timing

- Slot length: exactly PRESCALE enabled cycles. Frame length: 4·PRESCALE enabled cycles.
- Blanking: the first BLANK_CYCLES cycles of each slot have an=1111. The remaining PRESCALE-BLANK_CYCLES cycles drive the active anode low.
- Snapshot latency: value sampled at the wrap edge is visible on digit in the same cycle that sel=0001 and frame_tick=1.
- After rst_n deasserts with en=1: slot 0 lasts PRESCALE cycles. The first frame_tick occurs 4·PRESCALE cycles after the reset edge.
- Simultaneous en falling and terminal count: en wins; cnt and slot hold with no advance.
- rst_n=0 overrides en.

## Configuration

- LEADING_ZERO_BLANK_EN:
  - Defined: in slot k (k=1..3), an is forced to 4'b1111 whenever shadow nibbles k..3 are all zero. Slot 0 is never suppressed, so value 0 shows a single "0". sel, digit and frame_tick are unaffected.
  - Undefined: all four digits are lit per the normal an rule.

## Test plan

Bench parameters: PRESCALE=4, BLANK_CYCLES=1.

1. Reset for 3 cycles, then en=1, value=16'h1234:
   - sel steps 0001→0010→0100→1000 every 4 cycles.
   - an pattern per slot is 1111, then ~sel for 3 cycles.
   - digit=0 for the first frame.
   - frame_tick fires at cycle 16 after release, with digit=4 and sel=0001.
2. Change value from 16'h1234 to 16'hABCD mid-frame: digit stays on 1234 nibbles until the next frame_tick, then shows D, C, B, A across slots 0..3.
3. en=0 for 10 cycles in slot 2:
   - an=1111 and sel=0100 held; no frame_tick.
   - On re-enable, slot 2 completes its remaining cycles, then advances to 1000.
4. Assert rst_n=0 mid-slot 3:
   - Next edge gives sel=0001, an=1111, digit=0, shadow=0.
   - First frame_tick comes 16 cycles after release.
5. With LEADING_ZERO_BLANK_EN defined and value=16'h0050 captured:
   - Slots 2 and 3 keep an=1111; slots 0 and 1 are lit.
   - With value=0, only slot 0 is lit. Without the macro, all four slots are lit.
6. BLANK_CYCLES=0, PRESCALE=2: an is never 1111 while en=1, and sel changes every 2 cycles.
